// File: rtl/one_wire_crc_engine.sv
// ---------------------------------------------------------------------------
// one_wire_crc_engine
//
// Bit-serial CRC engine for the 1-Wire datapath. It absorbs data LSB first,
// one bit on each cycle that i_bit_valid is high. The message length is
// chosen at run time and is sampled together with i_start. It covers the
// Dallas CRC-8 used for ROM and scratchpad data, and the CRC-16 used by
// memory commands.
//
// Two modes use the same hardware:
//  - Generate mode: send only the message. o_crc_data holds the CRC.
//  - Check mode: send the message followed by its CRC. o_crc_ok goes high
//    when the running register lands on RESIDUE.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         asynchronous reset, active high
//   i_start       one-cycle pulse: load INIT, sample i_nbits, begin a run
//   i_nbits       number of message bits in this run
//   i_bit_in      serial data bit, LSB first
//   i_bit_valid   i_bit_in is valid this cycle
//   i_abort       cancel the current run without producing a result
//   o_busy        high from the cycle after start through the result cycle
//   o_crc_data    registered result (running ^ XOR_OUT)
//   o_crc_valid   one-cycle pulse when o_crc_data / o_crc_ok are updated
//   o_crc_ok      registered (running == RESIDUE) from the last completion
// ---------------------------------------------------------------------------
module one_wire_crc_engine #(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = 'h8C,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter logic [CRC_W-1:0] RESIDUE = '0,
  parameter int               CNT_W   = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_nbits,
  input  logic             i_bit_in,
  input  logic             i_bit_valid,
  input  logic             i_abort,
  output logic             o_busy,
  output logic [CRC_W-1:0] o_crc_data,
  output logic             o_crc_valid,
  output logic             o_crc_ok
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CRC_W-1:0] r_running;
  logic [CNT_W-1:0] r_bitCount;
  logic [CRC_W-1:0] r_crcData;
  logic             r_crcOk;

  logic             w_startAccept;
  logic             w_absorb;
  logic             w_lastBit;
  logic             w_fb;
  logic [CRC_W-1:0] w_stepped;

  // Abort takes priority over start, so a start that arrives in the same
  // cycle as an abort is dropped. The start cycle never absorbs a bit.
  assign w_startAccept = i_start & ~i_abort;
  assign w_absorb      = (r_state == S_CALC) & i_bit_valid & ~i_start & ~i_abort;
  assign w_lastBit     = w_absorb & (r_bitCount == CNT_W'(1));

  // Reflected LFSR step: shift right, and fold the polynomial back in
  // whenever the bit leaving the register differs from the incoming bit.
  always_comb begin
    w_fb      = r_running[0] ^ i_bit_in;
    w_stepped = (r_running >> 1) ^ (w_fb ? POLY : '0);
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and FSM outputs. A start in CALC or DONE restarts the
  // run as if it came from IDLE. That also cancels a result pulse that has
  // not yet been issued.
  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b0;
    o_crc_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_startAccept) begin
          w_nextState = (i_nbits == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        o_busy = 1'b1;
        if (i_abort) begin
          w_nextState = S_IDLE;
        end else if (i_start) begin
          w_nextState = (i_nbits == '0) ? S_DONE : S_CALC;
        end else if (w_lastBit) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_crc_valid = 1'b1;
        if (i_abort) begin
          w_nextState = S_IDLE;
        end else if (i_start) begin
          w_nextState = (i_nbits == '0) ? S_DONE : S_CALC;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath. The result registers load on the same edge that moves the
  // FSM into DONE, so the data is already visible while o_crc_valid is high.
  // A zero-length run completes straight from the start edge with INIT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_running  <= '0;
      r_bitCount <= '0;
      r_crcData  <= '0;
      r_crcOk    <= 1'b0;
    end else if (w_startAccept) begin
      r_running  <= INIT;
      r_bitCount <= i_nbits;
      if (i_nbits == '0) begin
        r_crcData <= INIT ^ XOR_OUT;
        r_crcOk   <= (INIT == RESIDUE);
      end else begin
        r_crcOk   <= 1'b0;
      end
    end else if (w_absorb) begin
      r_running  <= w_stepped;
      r_bitCount <= r_bitCount - CNT_W'(1);
      if (w_lastBit) begin
        r_crcData <= w_stepped ^ XOR_OUT;
        r_crcOk   <= (w_stepped == RESIDUE);
      end
    end
  end

  assign o_crc_data = r_crcData;
  assign o_crc_ok   = r_crcOk;

endmodule
